// File: rtl/ttl_ripple_sequencer.sv
// Emulated SN74107 ripple-counter chain, resolved one stage per CLK_DRV cycle.
// Falling CLK_N_IN edges that arrive while a ripple is in flight are queued up to QUEUE_DEPTH.
module ttl_ripple_sequencer #(
    parameter int STAGES      = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic              CLK_DRV,
    input  logic              RST_N,
    input  logic              CLK_N_IN,
    input  logic              CLR_N,
    input  logic [STAGES-1:0] J,
    input  logic [STAGES-1:0] K,
    output logic [STAGES-1:0] Q,
    output logic [STAGES-1:0] Q_N,
    output logic [STAGES-1:0] STAGE_EN,
    output logic              BUSY,
    output logic              OVERRUN
);

    localparam int PW = $clog2(QUEUE_DEPTH + 1);
    localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic {
        IDLE,
        RIPPLE
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [PW-1:0]     pend_q, pend_d;
    logic [STAGES-1:0] q_q, q_d;
    logic              ovr_q, ovr_d;
    logic              clk_s_q, clk_p_q, clr_s_q;
    logic              edge_det, launch, cur, nxt;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   jk_next = q;
            2'b01:   jk_next = 1'b0;
            2'b10:   jk_next = 1'b1;
            default: jk_next = ~q;
        endcase
    endfunction

    assign edge_det = clk_p_q & ~clk_s_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        q_d      = q_q;
        ovr_d    = ovr_q;
        STAGE_EN = '0;
        launch   = 1'b0;
        cur      = 1'b0;
        nxt      = 1'b0;
        if (!clr_s_q) begin
            // Clear wins: abort any ripple and drop queued and arriving edges.
            q_d     = '0;
            pend_d  = '0;
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (edge_det || (pend_q != '0)) begin
                        launch  = 1'b1;
                        state_d = RIPPLE;
                        idx_d   = '0;
                    end
                end
                RIPPLE: begin
                    STAGE_EN[idx_q] = 1'b1;
                    cur             = q_q[idx_q];
                    nxt             = jk_next(cur, J[idx_q], K[idx_q]);
                    q_d[idx_q]      = nxt;
                    if (cur && !nxt && (idx_q != IW'(STAGES - 1)))
                        idx_d = idx_q + IW'(1);
                    else
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // A launch fed straight from a fresh edge leaves the queue untouched.
            if (edge_det && !launch) begin
                if (pend_q == PW'(QUEUE_DEPTH))
                    ovr_d = 1'b1;
                else
                    pend_d = pend_q + PW'(1);
            end else if (!edge_det && launch) begin
                pend_d = pend_q - PW'(1);
            end
        end
    end

    always_ff @(posedge CLK_DRV) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            q_q     <= '0;
            ovr_q   <= 1'b0;
            clk_s_q <= 1'b0;
            clk_p_q <= 1'b0;
            clr_s_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            q_q     <= q_d;
            ovr_q   <= ovr_d;
            clk_s_q <= CLK_N_IN;
            clk_p_q <= clk_s_q;
            clr_s_q <= CLR_N;
        end
    end

    assign Q       = q_q;
    assign Q_N     = ~q_q;
    assign BUSY    = (state_q != IDLE) || (pend_q != '0);
    assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_ttl_ripple_sequencer.sv
// Directed bench for ttl_ripple_sequencer (STAGES=4, QUEUE_DEPTH=4) with hand-computed expectations.
module tb_ttl_ripple_sequencer;

    logic       clk = 1'b0;
    logic       RST_N, CLK_N_IN, CLR_N;
    logic [3:0] J, K, Q, Q_N, STAGE_EN;
    logic       BUSY, OVERRUN;

    int n_cmp = 0;
    int n_err = 0;

    ttl_ripple_sequencer #(.STAGES(4), .QUEUE_DEPTH(4)) dut (
        .CLK_DRV(clk), .RST_N(RST_N), .CLK_N_IN(CLK_N_IN), .CLR_N(CLR_N),
        .J(J), .K(K), .Q(Q), .Q_N(Q_N), .STAGE_EN(STAGE_EN),
        .BUSY(BUSY), .OVERRUN(OVERRUN)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One falling edge followed by enough quiet time for a full 4-stage ripple.
    task automatic edge_slow();
        CLK_N_IN = 1'b0;
        tick();
        CLK_N_IN = 1'b1;
        tick(7);
    endtask

    // Back-to-back falling edges, one every 2 cycles.
    task automatic edges_fast(input int n);
        for (int i = 0; i < n; i++) begin
            CLK_N_IN = 1'b0;
            tick();
            CLK_N_IN = 1'b1;
            tick();
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (BUSY && cyc < 64) begin
            tick();
            cyc++;
        end
        chk1("idle_timeout", BUSY, 1'b0);
    endtask

    task automatic quiet_window(input string tag, input int n);
        int pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (STAGE_EN != 4'b0000) pulses++;
        end
        chki(tag, pulses, 0);
    endtask

    function automatic logic sn74107(input logic q, input logic j, input logic k);
        if (j && k)       return ~q;
        else if (j)       return 1'b1;
        else if (k)       return 1'b0;
        else              return q;
    endfunction

    initial begin
        logic [3:0] sten[7];
        logic [1:0] jk_vec[5];
        logic       exp0[5];
        logic       mq;
        int         qn_bad, cyc;

        jk_vec = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b00};
        exp0   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        // Reset with CLK_N_IN toggling, release with CLK_N_IN low
        RST_N = 1'b0; CLR_N = 1'b1; J = 4'hF; K = 4'hF; CLK_N_IN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CLK_N_IN = ~CLK_N_IN;
            tick();
        end
        chk4("rst_q", Q, 4'b0000);
        chk4("rst_qn", Q_N, 4'b1111);
        chk4("rst_sten", STAGE_EN, 4'b0000);
        chk1("rst_busy", BUSY, 1'b0);
        chk1("rst_ovr", OVERRUN, 1'b0);
        CLK_N_IN = 1'b0;
        RST_N    = 1'b1;
        quiet_window("rst_low_clk_no_edge", 10);
        chk1("rst_release_busy", BUSY, 1'b0);
        CLK_N_IN = 1'b1;
        tick(2);

        // Binary count through wrap, with carry timing on 7->8
        qn_bad = 0;
        for (int n = 0; n < 16; n++) begin
            CLK_N_IN = 1'b0;
            tick();
            CLK_N_IN = 1'b1;
            for (int c = 0; c < 7; c++) begin
                tick();
                sten[c] = STAGE_EN;
                if (Q_N !== ~Q) qn_bad++;
            end
            chk4("count_q", Q, 4'(n + 1));
            if (n == 7) begin
                chk4("carry_sten0", sten[0], 4'b0001);
                chk4("carry_sten1", sten[1], 4'b0010);
                chk4("carry_sten2", sten[2], 4'b0100);
                chk4("carry_sten3", sten[3], 4'b1000);
                chk4("carry_sten4", sten[4], 4'b0000);
            end
        end
        chki("qn_is_not_q", qn_bad, 0);

        // JK modes on stage 0, upper stages held
        mq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            J = {3'b000, jk_vec[i][1]};
            K = {3'b000, jk_vec[i][0]};
            edge_slow();
            mq = sn74107(mq, jk_vec[i][1], jk_vec[i][0]);
            chk1("jk_model", Q[0], mq);
            chk1("jk_table", Q[0], exp0[i]);
            chk4("jk_upper_hold", {1'b0, Q[3:1]}, 4'b0000);
        end
        J = 4'hF; K = 4'hF;

        // Queueing: 0111 + 3 fast edges -> 1010
        for (int i = 0; i < 7; i++) edge_slow();
        chk4("q_pre_queue", Q, 4'b0111);
        edges_fast(3);
        chk1("queue_busy", BUSY, 1'b1);
        wait_idle(cyc);
        chki("queue_busy_fall_cycles", cyc, 5);
        chk4("queue_q", Q, 4'b1010);
        chk1("queue_no_ovr", OVERRUN, 1'b0);

        // Overrun: from 1111, 14 fast edges; the last one is dropped -> 1111 + 13 = 1100
        for (int i = 0; i < 5; i++) edge_slow();
        chk4("q_pre_ovr", Q, 4'b1111);
        edges_fast(14);
        wait_idle(cyc);
        chk1("ovr_set", OVERRUN, 1'b1);
        chk4("ovr_q_accepted", Q, 4'b1100);

        // Clear mid-ripple
        for (int i = 0; i < 3; i++) edge_slow();
        chk4("q_pre_clr", Q, 4'b1111);
        CLK_N_IN = 1'b0;
        tick();
        CLK_N_IN = 1'b1;
        tick();
        chk4("clr_sten_r0", STAGE_EN, 4'b0001);
        tick();
        chk4("clr_sten_r1", STAGE_EN, 4'b0010);
        CLR_N = 1'b0;
        tick();
        chk4("clr_sten_gated", STAGE_EN, 4'b0000);
        chk4("clr_partial_q", Q, 4'b1100);
        tick();
        chk4("clr_q", Q, 4'b0000);
        chk1("clr_busy", BUSY, 1'b0);
        chk1("clr_keeps_ovr", OVERRUN, 1'b1);
        CLK_N_IN = 1'b0;
        tick(3);
        CLR_N = 1'b1;
        quiet_window("clr_release_no_edge", 10);
        chk4("clr_release_q", Q, 4'b0000);
        CLK_N_IN = 1'b1;
        tick();
        edge_slow();
        chk4("clr_next_edge_q", Q, 4'b0001);

        // Reset during RIPPLE(2) with two edges queued
        for (int i = 0; i < 14; i++) edge_slow();
        chk4("q_pre_rst", Q, 4'b1111);
        edges_fast(7);
        tick(2);
        chk4("rst_mid_sten", STAGE_EN, 4'b0100);
        chk1("rst_mid_busy", BUSY, 1'b1);
        chk4("rst_mid_q", Q, 4'b0000);
        RST_N = 1'b0;
        tick();
        chk4("rst2_q", Q, 4'b0000);
        chk4("rst2_qn", Q_N, 4'b1111);
        chk4("rst2_sten", STAGE_EN, 4'b0000);
        chk1("rst2_busy", BUSY, 1'b0);
        chk1("rst2_ovr", OVERRUN, 1'b0);
        RST_N = 1'b1;
        quiet_window("rst2_queue_discarded", 10);
        chk4("rst2_q_after", Q, 4'b0000);
        chk1("rst2_busy_after", BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
